// File: rtl/xlr8_tone_pkg.sv
// xlr8_tone_pkg
// Shared definitions for the XLR8 tone mixer: register offsets within a
// channel's four-byte window, the channel state encoding and the sample width.
// No ports (package only).

package xlr8_tone_pkg;

  localparam logic [1:0] REG_RATE     = 2'd0;
  localparam logic [1:0] REG_VOLUME   = 2'd1;
  localparam logic [1:0] REG_DURATION = 2'd2;
  localparam logic [1:0] REG_STATUS   = 2'd3;

  localparam int SAMPLE_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } ch_state_t;

endpackage

// File: rtl/xlr8_tone_chan.sv
// xlr8_tone_chan
// One tone channel: RATE/VOLUME registers, IDLE/PLAY state machine with a
// remaining-tick counter, phase accumulator and volume-scaled sample output.
// Optional linear fade is built when XLR8_TONE_DECAY_EN is defined.
//
// Ports:
//   clk_core     core clock
//   rstn         synchronous active-low reset
//   i_tick       one-cycle duration tick from the shared prescaler
//   i_rateWe     write strobe for RATE
//   i_volWe      write strobe for VOLUME
//   i_durWe      write strobe for DURATION
//   i_wdata      write data
//   o_rate       RATE register value
//   o_volume     VOLUME register value
//   o_remaining  remaining tick count (DURATION read-back)
//   o_active     1 while the channel is in PLAY
//   o_sample     unsigned channel sample, 0 when idle

module xlr8_tone_chan
  import xlr8_tone_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic                clk_core,
  input  logic                rstn,
  input  logic                i_tick,
  input  logic                i_rateWe,
  input  logic                i_volWe,
  input  logic                i_durWe,
  input  logic [7:0]          i_wdata,
  output logic [7:0]          o_rate,
  output logic [7:0]          o_volume,
  output logic [7:0]          o_remaining,
  output logic                o_active,
  output logic [SAMPLE_W-1:0] o_sample
);

  ch_state_t          r_state;
  logic [7:0]         r_rate;
  logic [7:0]         r_volume;
  logic [7:0]         r_remaining;
  logic [ACC_W-1:0]   r_phase;
  logic [7:0]         w_workVol;
  logic [SAMPLE_W-1:0] w_phaseMsb;

  // Bus-visible RATE and VOLUME; a write during PLAY only changes the
  // parameters used from the next cycle on, it never restarts the note.
  always_ff @(posedge clk_core) begin
    if (!rstn) begin
      r_rate   <= '0;
      r_volume <= '0;
    end else begin
      if (i_rateWe) r_rate <= i_wdata;
      if (i_volWe)  r_volume <= i_wdata;
    end
  end

  // Note state machine. A DURATION write wins over a coincident tick, so the
  // written count is loaded untouched; the last tick returns the channel to
  // IDLE on the same edge it reaches zero. Phase is parked at 0 while idle.
  always_ff @(posedge clk_core) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_phase     <= '0;
    end else if (i_durWe) begin
      r_remaining <= i_wdata;
      r_phase     <= '0;
      r_state     <= (i_wdata != 8'd0) ? PLAY : IDLE;
    end else begin
      case (r_state)
        IDLE: r_phase <= '0;
        PLAY: begin
          if (i_tick && r_remaining == 8'd1) begin
            r_remaining <= 8'd0;
            r_phase     <= '0;
            r_state     <= IDLE;
          end else begin
            if (i_tick) r_remaining <= r_remaining - 8'd1;
            r_phase <= r_phase + ACC_W'(r_rate);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef XLR8_TONE_DECAY_EN
  logic [7:0] r_workVol;

  // Working volume is seeded at note start (or by a VOLUME write) and then
  // drops by one per tick while playing, stopping at zero.
  always_ff @(posedge clk_core) begin
    if (!rstn) begin
      r_workVol <= '0;
    end else if (i_durWe) begin
      r_workVol <= r_volume;
    end else if (i_volWe) begin
      r_workVol <= i_wdata;
    end else if (i_tick && r_state == PLAY && r_workVol != 8'd0) begin
      r_workVol <= r_workVol - 8'd1;
    end
  end

  assign w_workVol = r_workVol;
`else
  assign w_workVol = r_volume;
`endif

  // Sawtooth from the top phase bits, scaled by volume; the product is kept
  // 16 bits wide so the upper byte survives the shift.
  assign w_phaseMsb  = r_phase[ACC_W-1 -: SAMPLE_W];
  assign o_sample    = (r_state == PLAY)
                       ? SAMPLE_W'((16'(w_phaseMsb) * 16'(w_workVol)) >> SAMPLE_W)
                       : '0;
  assign o_rate      = r_rate;
  assign o_volume    = r_volume;
  assign o_remaining = r_remaining;
  assign o_active    = (r_state == PLAY);

endmodule

// File: rtl/xlr8_tone_mixer.sv
// xlr8_tone_mixer
// Memory-mapped multi-channel tone generator for the XLR8 AVR core. Each
// channel has RATE, VOLUME, DURATION and read-only STATUS registers at
// BASE_ADDR + 4*ch + k. A free-running prescaler produces the duration tick;
// channel samples are summed and scaled down into one registered audio byte.
// Define XLR8_TONE_DECAY_EN to build the per-tick linear volume fade.
//
// Ports:
//   clk_core      core clock
//   rstn          synchronous active-low reset
//   clken         core clock enable, qualifies register writes
//   dbus_in       write data from the core
//   dbus_out      combinational read data, 0 when nothing selected
//   io_out_en     read-data valid
//   ramadr        data-memory address
//   ramre/ramwe   read/write strobes
//   dm_sel        data-memory select
//   audio_sample  registered mixed unsigned sample
//   ch_active     per-channel playing flags

module xlr8_tone_mixer
  import xlr8_tone_pkg::*;
#(
  parameter int         NUM_CH    = 4,
  parameter logic [7:0] BASE_ADDR = 8'hE0,
  parameter int         TICK_DIV  = 1000000,
  parameter int         ACC_W     = 16
) (
  input  logic              clk_core,
  input  logic              rstn,
  input  logic              clken,
  input  logic [7:0]        dbus_in,
  output logic [7:0]        dbus_out,
  output logic              io_out_en,
  input  logic [7:0]        ramadr,
  input  logic              ramre,
  input  logic              ramwe,
  input  logic              dm_sel,
  output logic [7:0]        audio_sample,
  output logic [NUM_CH-1:0] ch_active
);

  localparam int MIX_SHIFT = $clog2(NUM_CH);
  localparam int SUM_W     = SAMPLE_W + MIX_SHIFT;
  localparam int PRESC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WIN_BYTES = 4 * NUM_CH;

  logic [7:0]          w_offset;
  logic                w_sel;
  logic                w_write;
  logic                w_tick;
  logic [PRESC_W-1:0]  r_presc;
  logic [SAMPLE_W-1:0] r_audio;
  logic [SUM_W-1:0]    w_sum;

  logic [7:0]          w_rate      [NUM_CH];
  logic [7:0]          w_volume    [NUM_CH];
  logic [7:0]          w_remaining [NUM_CH];
  logic [SAMPLE_W-1:0] w_sample    [NUM_CH];

  // Offset wraps modulo 256, so addresses below the base land far outside
  // the window and fail the single range compare.
  assign w_offset  = ramadr - BASE_ADDR;
  assign w_sel     = dm_sel && (w_offset < 8'(WIN_BYTES));
  assign w_write   = w_sel && ramwe && clken;
  assign io_out_en = w_sel && ramre;

  // Duration prescaler runs from reset regardless of clken; the tick is the
  // cycle in which the counter wraps.
  assign w_tick = (r_presc == PRESC_W'(TICK_DIV - 1));

  always_ff @(posedge clk_core) begin
    if (!rstn) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    logic w_chHit;
    assign w_chHit = w_write && (w_offset[7:2] == 6'(g));

    xlr8_tone_chan #(
      .ACC_W(ACC_W)
    ) u_chan (
      .clk_core    (clk_core),
      .rstn        (rstn),
      .i_tick      (w_tick),
      .i_rateWe    (w_chHit && (w_offset[1:0] == REG_RATE)),
      .i_volWe     (w_chHit && (w_offset[1:0] == REG_VOLUME)),
      .i_durWe     (w_chHit && (w_offset[1:0] == REG_DURATION)),
      .i_wdata     (dbus_in),
      .o_rate      (w_rate[g]),
      .o_volume    (w_volume[g]),
      .o_remaining (w_remaining[g]),
      .o_active    (ch_active[g]),
      .o_sample    (w_sample[g])
    );
  end

  // Read mux; STATUS exposes only the active flag in bit 0.
  always_comb begin
    dbus_out = '0;
    if (w_sel) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_offset[7:2] == 6'(c)) begin
          case (w_offset[1:0])
            REG_RATE:     dbus_out = w_rate[c];
            REG_VOLUME:   dbus_out = w_volume[c];
            REG_DURATION: dbus_out = w_remaining[c];
            default:      dbus_out = {7'd0, ch_active[c]};
          endcase
        end
      end
    end
  end

  // Mixer sum is wide enough for every channel at full scale, so dividing by
  // the channel count afterwards can never wrap.
  always_comb begin
    w_sum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_sum = w_sum + SUM_W'(w_sample[c]);
    end
  end

  always_ff @(posedge clk_core) begin
    if (!rstn) begin
      r_audio <= '0;
    end else begin
      r_audio <= SAMPLE_W'(w_sum >> MIX_SHIFT);
    end
  end

  assign audio_sample = r_audio;

endmodule

// File: tb/tb_xlr8_tone_mixer.sv
`timescale 1ns/1ps

module tb_xlr8_tone_mixer;

  localparam int         NUM_CH   = 4;
  localparam int         TICK_DIV = 10;
  localparam int         ACC_W    = 16;
  localparam logic [7:0] BASE     = 8'hE0;

  logic              clk_core = 1'b0;
  logic              rstn;
  logic              clken;
  logic [7:0]        dbus_in;
  logic [7:0]        dbus_out;
  logic              io_out_en;
  logic [7:0]        ramadr;
  logic              ramre;
  logic              ramwe;
  logic              dm_sel;
  logic [7:0]        audio_sample;
  logic [NUM_CH-1:0] ch_active;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the whole block, stepped once per clock edge.
  int mRate  [NUM_CH];
  int mVol   [NUM_CH];
  int mWork  [NUM_CH];
  int mRem   [NUM_CH];
  int mPhase [NUM_CH];
  bit mPlay  [NUM_CH];
  int mPresc;
  int mAudio;

  always #5 clk_core = ~clk_core;

  xlr8_tone_mixer #(
    .NUM_CH    (NUM_CH),
    .BASE_ADDR (BASE),
    .TICK_DIV  (TICK_DIV),
    .ACC_W     (ACC_W)
  ) dut (
    .clk_core     (clk_core),
    .rstn         (rstn),
    .clken        (clken),
    .dbus_in      (dbus_in),
    .dbus_out     (dbus_out),
    .io_out_en    (io_out_en),
    .ramadr       (ramadr),
    .ramre        (ramre),
    .ramwe        (ramwe),
    .dm_sel       (dm_sel),
    .audio_sample (audio_sample),
    .ch_active    (ch_active)
  );

  function automatic bit inWindow(input logic [7:0] a);
    return (int'(a) >= int'(BASE)) && (int'(a) < int'(BASE) + 4 * NUM_CH);
  endfunction

  function automatic int curVol(input int c);
`ifdef XLR8_TONE_DECAY_EN
    return mWork[c];
`else
    return mVol[c];
`endif
  endfunction

  function automatic int modelRead(input logic [7:0] a);
    int off;
    int ch;
    if (!inWindow(a)) return 0;
    off = int'(a) - int'(BASE);
    ch  = off / 4;
    case (off % 4)
      0:       return mRate[ch];
      1:       return mVol[ch];
      2:       return mRem[ch];
      default: return mPlay[ch] ? 1 : 0;
    endcase
  endfunction

  function automatic logic [NUM_CH-1:0] modelActive();
    logic [NUM_CH-1:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c] = mPlay[c];
    return v;
  endfunction

  // Advance the model across one edge using the inputs currently driven.
  function automatic void stepModel();
    bit tick;
    int sum;
    int wrCh;
    int wrK;
    int d;
    int oldRate;
    tick = (mPresc == TICK_DIV - 1);
    sum  = 0;
    for (int c = 0; c < NUM_CH; c++)
      if (mPlay[c]) sum += ((mPhase[c] / 256) * curVol(c)) / 256;
    if (!rstn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        mRate[c] = 0; mVol[c] = 0; mWork[c] = 0;
        mRem[c] = 0; mPhase[c] = 0; mPlay[c] = 0;
      end
      mPresc = 0;
      mAudio = 0;
      return;
    end
    mAudio = sum / NUM_CH;
    mPresc = (mPresc + 1) % TICK_DIV;
    wrCh = -1;
    wrK  = -1;
    d    = int'(dbus_in);
    if (dm_sel && ramwe && clken && inWindow(ramadr)) begin
      wrCh = (int'(ramadr) - int'(BASE)) / 4;
      wrK  = (int'(ramadr) - int'(BASE)) % 4;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      oldRate = mRate[c];
      if (c == wrCh && wrK == 2) begin
        mRem[c]   = d;
        mPhase[c] = 0;
        mPlay[c]  = (d != 0);
        mWork[c]  = mVol[c];
      end else if (mPlay[c]) begin
        if (tick) begin
          if (mWork[c] > 0) mWork[c] = mWork[c] - 1;
          mRem[c] = mRem[c] - 1;
          if (mRem[c] == 0) begin
            mPlay[c]  = 0;
            mPhase[c] = 0;
          end else begin
            mPhase[c] = (mPhase[c] + oldRate) % (1 << ACC_W);
          end
        end else begin
          mPhase[c] = (mPhase[c] + oldRate) % (1 << ACC_W);
        end
      end
      if (c == wrCh && wrK == 0) mRate[c] = d;
      if (c == wrCh && wrK == 1) begin
        mVol[c]  = d;
        mWork[c] = d;
      end
    end
  endfunction

  task automatic applyStimulus(input bit rn, input bit sel, input bit we, input bit re,
                               input logic [7:0] a, input logic [7:0] data, input bit en);
    rstn    = rn;
    dm_sel  = sel;
    ramwe   = we;
    ramre   = re;
    ramadr  = a;
    dbus_in = data;
    clken   = en;
    #2;
  endtask

  task automatic clockModel();
    @(posedge clk_core);
    stepModel();
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    clockModel();
  endtask

  task automatic writeReg(input logic [7:0] a, input logic [7:0] data);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, a, data, 1'b1);
    clockModel();
  endtask

  task automatic test_reset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    clockModel();
    clockModel();
    checks++;
    if (ch_active !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_active got=%b exp=%b", ch_active, 4'b0000);
    end
    checks++;
    if (audio_sample !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_audio got=%h exp=%h", audio_sample, 8'h00);
    end
    for (int a = 0; a < 4 * NUM_CH; a++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, BASE + 8'(a), 8'h00, 1'b1);
      checks++;
      if (dbus_out !== 8'h00 || io_out_en !== 1'b1) begin
        errors++;
        $display("[TB] FAIL reset_read addr=%h got=%h/%b exp=00/1", BASE + 8'(a), dbus_out, io_out_en);
      end
      clockModel();
    end
  endtask

  task automatic test_basic_note();
    int  n;
    bit  sawNonzero;
    writeReg(BASE + 8'd0, 8'h80);
    writeReg(BASE + 8'd1, 8'hFF);
    writeReg(BASE + 8'd2, 8'd3);
    checks++;
    if (ch_active[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL note_start got=%b exp=1", ch_active[0]);
    end
    n = 0;
    sawNonzero = 0;
    while (ch_active[0] === 1'b1 && n < 60) begin
      idleCycle();
      n++;
      checks++;
      if (audio_sample !== 8'(mAudio)) begin
        errors++;
        $display("[TB] FAIL note_audio cyc=%0d got=%h exp=%h", n, audio_sample, 8'(mAudio));
      end
      if (audio_sample != 8'h00) sawNonzero = 1;
    end
    checks++;
    if (n < 20 || n > 30) begin
      errors++;
      $display("[TB] FAIL note_length got=%0d exp=20..30", n);
    end
    checks++;
    if (!sawNonzero) begin
      errors++;
      $display("[TB] FAIL note_ramp got=all-zero exp=nonzero sample");
    end
    idleCycle();
    idleCycle();
    checks++;
    if (audio_sample !== 8'h00) begin
      errors++;
      $display("[TB] FAIL note_after got=%h exp=00", audio_sample);
    end
  endtask

  task automatic test_abort();
    writeReg(BASE + 8'd2, 8'd5);
    for (int i = 0; i < 12; i++) idleCycle();
    writeReg(BASE + 8'd2, 8'd0);
    checks++;
    if (ch_active[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_active got=%b exp=0", ch_active[0]);
    end
    checks++;
    if (audio_sample !== 8'(mAudio)) begin
      errors++;
      $display("[TB] FAIL abort_audio1 got=%h exp=%h", audio_sample, 8'(mAudio));
    end
    idleCycle();
    checks++;
    if (audio_sample !== 8'h00) begin
      errors++;
      $display("[TB] FAIL abort_audio2 got=%h exp=00", audio_sample);
    end
  endtask

  task automatic test_tick_collision();
    int n;
    writeReg(BASE + 8'd2, 8'd9);
    n = 0;
    while (mPresc != TICK_DIV - 1 && n < 20) begin
      idleCycle();
      n++;
    end
    writeReg(BASE + 8'd2, 8'd7);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, BASE + 8'd2, 8'h00, 1'b1);
    checks++;
    if (dbus_out !== 8'd7) begin
      errors++;
      $display("[TB] FAIL collision_dur got=%0d exp=7", dbus_out);
    end
    clockModel();
  endtask

  task automatic test_full_mix();
    logic [NUM_CH-1:0] frozen;
    logic [7:0]        expMix;
    int                hit;
    int                n;
    for (int c = 0; c < NUM_CH; c++) begin
      writeReg(BASE + 8'(4 * c + 1), 8'hFF);
      writeReg(BASE + 8'(4 * c), 8'hFF);
    end
    for (int c = 0; c < NUM_CH; c++) writeReg(BASE + 8'(4 * c + 2), 8'd255);
    // Freeze each phase at 0xFF00 by zeroing RATE in the cycle before.
    frozen = '0;
    n = 0;
    while (frozen != '1 && n < 400) begin
      hit = -1;
      for (int c = 0; c < NUM_CH; c++)
        if (!frozen[c] && mPhase[c] == 16'hFE01) hit = c;
      if (hit >= 0) begin
        writeReg(BASE + 8'(4 * hit), 8'h00);
        frozen[hit] = 1'b1;
      end else begin
        idleCycle();
      end
      n++;
    end
    checks++;
    if (frozen != '1) begin
      errors++;
      $display("[TB] FAIL mix_setup_timeout got=%b exp=1111", frozen);
    end
    idleCycle();
    idleCycle();
`ifdef XLR8_TONE_DECAY_EN
    expMix = 8'(mAudio);
`else
    expMix = 8'hFE;
`endif
    checks++;
    if (ch_active !== 4'hF) begin
      errors++;
      $display("[TB] FAIL mix_active got=%b exp=1111", ch_active);
    end
    checks++;
    if (audio_sample !== expMix) begin
      errors++;
      $display("[TB] FAIL mix_full got=%h exp=%h", audio_sample, expMix);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, BASE + 8'd1, 8'h00, 1'b1);
    checks++;
    if (dbus_out !== 8'h00 || io_out_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL unselected_read got=%h/%b exp=00/0", dbus_out, io_out_en);
    end
    clockModel();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, BASE + 8'd1, 8'h00, 1'b1);
    checks++;
    if (dbus_out !== 8'hFF || io_out_en !== 1'b1) begin
      errors++;
      $display("[TB] FAIL selected_read got=%h/%b exp=ff/1", dbus_out, io_out_en);
    end
    clockModel();
  endtask

  task automatic test_reset_midnote();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    clockModel();
    checks++;
    if (ch_active !== 4'b0000 || audio_sample !== 8'h00) begin
      errors++;
      $display("[TB] FAIL midreset_out got=%b/%h exp=0000/00", ch_active, audio_sample);
    end
    for (int a = 0; a < 4 * NUM_CH; a++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, BASE + 8'(a), 8'h00, 1'b1);
      checks++;
      if (dbus_out !== 8'h00) begin
        errors++;
        $display("[TB] FAIL midreset_read addr=%h got=%h exp=00", BASE + 8'(a), dbus_out);
      end
      clockModel();
    end
    checks++;
    if (ch_active !== 4'b0000 || audio_sample !== 8'h00) begin
      errors++;
      $display("[TB] FAIL midreset_resume got=%b/%h exp=0000/00", ch_active, audio_sample);
    end
  endtask

`ifdef XLR8_TONE_DECAY_EN
  task automatic test_decay();
    int ticks;
    int n;
    writeReg(BASE + 8'd0, 8'hFF);
    writeReg(BASE + 8'd1, 8'd2);
    writeReg(BASE + 8'd2, 8'd5);
    ticks = 0;
    n = 0;
    while (ticks < 2 && n < 40) begin
      if (mPresc == TICK_DIV - 1) ticks++;
      idleCycle();
      n++;
    end
    idleCycle();
    checks++;
    if (ch_active[0] !== 1'b1 || audio_sample !== 8'h00) begin
      errors++;
      $display("[TB] FAIL decay_silent got=%b/%h exp=1/00", ch_active[0], audio_sample);
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] a;
    logic [7:0] data;
    logic [7:0] expBus;
    bit         sel;
    bit         en;
    int         op;
    for (int i = 0; i < 600; i++) begin
      a = ($urandom_range(0, 9) == 0) ? 8'($urandom) : BASE + 8'($urandom_range(0, 15));
      data = (inWindow(a) && ((int'(a) - int'(BASE)) % 4 == 2))
             ? 8'($urandom_range(0, 6)) : 8'($urandom);
      sel = ($urandom_range(0, 9) != 0);
      en  = ($urandom_range(0, 9) != 0);
      op  = $urandom_range(0, 2);
      applyStimulus(1'b1, sel, op == 1, op == 2, a, data, en);
      expBus = (sel && inWindow(a)) ? 8'(modelRead(a)) : 8'h00;
      checks++;
      if (dbus_out !== expBus || io_out_en !== (sel && inWindow(a) && op == 2)) begin
        errors++;
        $display("[TB] FAIL rnd_read i=%0d addr=%h got=%h/%b exp=%h/%b", i, a, dbus_out,
                 io_out_en, expBus, (sel && inWindow(a) && op == 2));
      end
      clockModel();
      checks++;
      if (audio_sample !== 8'(mAudio) || ch_active !== modelActive()) begin
        errors++;
        $display("[TB] FAIL rnd_out i=%0d got=%h/%b exp=%h/%b", i, audio_sample, ch_active,
                 8'(mAudio), modelActive());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_note();
    test_abort();
    test_tick_collision();
    test_full_mix();
    test_reset_midnote();
`ifdef XLR8_TONE_DECAY_EN
    test_decay();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xlr8_tone_mixer.md
XLR8_TONE_MIXER -- requirements
Module: xlr8_tone_mixer

Interface
REQ-001 Parameter NUM_CH, default 4: number of tone channels; legal values 1, 2 and 4.
REQ-002 Parameter BASE_ADDR, default 8'hE0: data-memory address of the channel 0 rate register.
REQ-003 Parameter TICK_DIV, default 1000000: clk_core cycles per duration tick (62.5 ms at 16 MHz).
REQ-004 Parameter ACC_W, default 16: phase accumulator width; legal range 9 to 24.
REQ-005 Port clk_core, input, 1: the only clock.
REQ-006 Port rstn, input, 1: reset; synchronous and active-low.
REQ-007 Port clken, input, 1: core clock enable; gates register writes only.
REQ-008 Port dbus_in, input, 8: write data from the AVR core.
REQ-009 Port dbus_out, output, 8: read data to the AVR core.
REQ-010 Port io_out_en, output, 1: read-data valid.
REQ-011 Port ramadr, input, 8: data-memory address.
REQ-012 Port ramre, input, 1: read strobe.
REQ-013 Port ramwe, input, 1: write strobe.
REQ-014 Port dm_sel, input, 1: data-memory select.
REQ-015 Port audio_sample, output, 8: mixed unsigned audio sample.
REQ-016 Port ch_active, output, NUM_CH: per-channel playing flag.

Function
REQ-017 Register map: address BASE_ADDR+4*ch+k, where k=0 is RATE, k=1 is VOLUME, k=2 is DURATION and k=3 is STATUS (read-only, bit0 = active).
REQ-018 Address decode: sel = dm_sel && address match; write = sel && ramwe && clken; io_out_en = sel && ramre.
REQ-019 dbus_out shall be combinational: the selected register value, or 0 when no register is selected.
REQ-020 Reading DURATION shall return the remaining tick count.
REQ-021 Each channel shall run a two-state FSM with states IDLE and PLAY.
REQ-022 Writing D>0 to DURATION shall, on the next cycle: enter PLAY, load remaining=D, clear the phase to 0, and load the working volume from VOLUME.
REQ-023 Writing 0 to DURATION shall force IDLE on the next cycle, whatever the current state.
REQ-024 The tick prescaler shall run freely from reset, counting 0 to TICK_DIV-1 and wrapping; tick is a one-cycle pulse at the wrap.
REQ-025 On a tick in PLAY, remaining shall decrement by 1; a channel whose remaining goes 1->0 enters IDLE on the same edge.
REQ-026 A DURATION write coincident with a tick shall take priority; that tick is not applied to the channel.
REQ-027 RATE and VOLUME writes during PLAY shall take effect on the next cycle and shall not restart the note.
REQ-028 In PLAY, phase += zero-extended RATE every cycle, wrapping modulo 2^ACC_W; in IDLE, phase holds at 0.
REQ-029 Channel sample = (phase[ACC_W-1:ACC_W-8] * working volume) >> 8, giving 8 bits unsigned; the sample is 0 in IDLE.
REQ-030 Mix = sum of channel samples >> log2(NUM_CH), with no overflow or saturation.
REQ-031 audio_sample shall be registered, one cycle after the phase update.
REQ-032 ch_active shall be registered, equal to (state==PLAY).

Reset
REQ-033 While rstn=0 at a clk_core edge: all RATE, VOLUME and remaining registers = 0, phase = 0, prescaler = 0, states = IDLE, audio_sample = 0, ch_active = 0.
REQ-034 Reset mid-note shall abort the note; no note resumes after reset deasserts.

Configuration
REQ-035 Macro XLR8_TONE_DECAY_EN defined: on each tick in PLAY, the working volume decrements by 1, saturating at 0, giving a linear fade.
REQ-036 Macro XLR8_TONE_DECAY_EN undefined: the working volume tracks VOLUME continuously and there is no decay logic.

Structure
REQ-037 Package xlr8_tone_pkg shall hold: the register offset constants (RATE=0, VOLUME=1, DURATION=2, STATUS=3), the ch_state_t enum (IDLE, PLAY) and the SAMPLE_W=8 constant.
REQ-038 Sub-module xlr8_tone_chan shall implement one channel (FSM, phase accumulator, remaining counter, volume scaling); it is instantiated NUM_CH times by a generate loop.
REQ-039 Decode, prescaler and mixer shall live in the top module.

Verification
REQ-040 With TICK_DIV=10 and NUM_CH=4: write ch0 RATE=0x80, VOLUME=0xFF, DURATION=3 -> ch_active[0]=1 next cycle; falls to 0 after the third tick (20 to 30 cycles later); audio_sample ramps while active and is 0 afterwards.
REQ-041 ch0 playing with remaining=5; write DURATION=0 -> ch_active[0]=0 next cycle; audio_sample=0 within 2 cycles.
REQ-042 DURATION write on the same cycle as the tick pulse -> read-back DURATION equals the written value, not value-1.
REQ-043 All 4 channels playing with VOLUME=0xFF and phase MSBs=0xFF -> audio_sample = (4*0xFE)>>2 = 0xFE, with no wrap.
REQ-044 rstn=0 for 1 cycle mid-note -> all registers read 0, ch_active=0, audio_sample=0; a read with dm_sel=0 gives io_out_en=0 and dbus_out=0.
REQ-045 With XLR8_TONE_DECAY_EN defined: VOLUME=2, DURATION=5 -> working volume goes 2, 1, 0, 0 on successive ticks, and audio_sample=0 from the second tick on while ch_active stays 1.
